// File: rtl/ila_refinement_monitor.sv
// ILA refinement monitor: tracks one issued instruction through fixed-cycle end checks and grades the refinement maps.
// Latency: start 1 cycle after issue; end strobes combinational at END_CYCLE / END2_CYCLE; verdict flags register 1 edge later.
// Backpressure: none; issue while tracking is ignored, and commit writes are dropped once the first end has passed.
//
// Ports:
//   clk, rst            sole clock, synchronous active-high reset
//   issue               request to begin tracking one instruction
//   ila_valid/decode    sampled into the qualifier on the start edge
//   map_eq, map_en      per-map equality results and run-time enables
//   commit_*            per-channel commit registers (reset load, write enable, data, current value)
//   start..reseted      phase flags; cycle_cnt saturating cycle counter
//   iend, iend2         single-cycle end strobes; mem_compare = iend | ended
//   pass, fail, vacuous verdict; fail_idx lowest failing map index at first failure
module ila_refinement_monitor #(
    parameter int NUM_MAP    = 16,
    parameter int END_CYCLE  = 4,
    parameter int END2_CYCLE = 6,
    parameter int MAX_CYCLE  = 9,
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 9,
    parameter logic [NUM_MAP-1:0] END_MASK  = '1,
    parameter logic [NUM_MAP-1:0] END2_MASK = '1,
    localparam int CNT_W  = $clog2(MAX_CYCLE + 1),
    localparam int FIDX_W = (NUM_MAP > 1) ? $clog2(NUM_MAP) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue,
    input  logic                     ila_valid,
    input  logic                     ila_decode,
    input  logic [NUM_MAP-1:0]       map_eq,
    input  logic [NUM_MAP-1:0]       map_en,
    input  logic [NUM_CH*DATA_W-1:0] commit_init,
    input  logic [NUM_CH-1:0]        commit_we,
    input  logic [NUM_CH*DATA_W-1:0] commit_din,
    output logic [NUM_CH*DATA_W-1:0] commit_q,
    output logic                     start,
    output logic                     started,
    output logic                     ended,
    output logic                     ended2,
    output logic                     reseted,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic                     iend,
    output logic                     iend2,
    output logic                     mem_compare,
    output logic                     pass,
    output logic                     fail,
    output logic                     vacuous,
    output logic [FIDX_W-1:0]        fail_idx
);

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CYCLE);
    localparam logic [CNT_W-1:0] END_C  = CNT_W'(END_CYCLE);
    localparam logic [CNT_W-1:0] END2_C = CNT_W'(END2_CYCLE);

    logic                     start_q, start_d;
    logic                     started_q, started_d;
    logic                     ended_q, ended_d;
    logic                     ended2_q, ended2_d;
    logic                     reseted_q, reseted_d;
    logic                     qual_q, qual_d;
    logic                     pass_q, pass_d;
    logic                     fail_q, fail_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [FIDX_W-1:0]        fidx_q, fidx_d;
    logic [NUM_CH*DATA_W-1:0] commit_d;

    logic [NUM_MAP-1:0] bad1, bad2, fail_vec;
    logic               iend_c, iend2_c, fail_now, pass_now;
    logic [FIDX_W-1:0]  low_idx;

    always_comb begin
        // End strobes are combinational so the maps are graded in the same cycle they are presented.
        iend_c  = started_q & reseted_q & ~ended_q & (cnt_q == END_C);
        iend2_c = ended_q & ~ended2_q & started_q & (cnt_q == END2_C);

        bad1     = ~map_eq & map_en & END_MASK;
        bad2     = ~map_eq & map_en & END2_MASK;
        fail_now = qual_q & ((iend_c & |bad1) | (iend2_c & |bad2));
        pass_now = qual_q & iend_c & ~|bad1;

        // iend and iend2 are mutually exclusive (one needs ~ended, the other ended).
        fail_vec = iend_c ? bad1 : bad2;
        low_idx  = '0;
        for (int i = NUM_MAP - 1; i >= 0; i--) begin
            if (fail_vec[i]) low_idx = FIDX_W'(i);
        end

        start_d   = start_q ? 1'b0 : (issue & ~started_q);
        started_d = started_q | start_q;
        cnt_d     = ((start_q | started_q) && (cnt_q < MAX_C)) ? cnt_q + 1'b1 : cnt_q;
        ended_d   = ended_q | iend_c;
        ended2_d  = ended2_q | iend2_c;
        reseted_d = reseted_q;
        qual_d    = start_q ? (ila_valid & ila_decode) : qual_q;
        fail_d    = fail_q | fail_now;
        // A later failure overrides an earlier pass so the two are never both set.
        pass_d    = fail_now ? 1'b0 : (pass_q | pass_now);
        fidx_d    = (fail_now && !fail_q) ? low_idx : fidx_q;

        commit_d = commit_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (commit_we[ch] && !ended_q) begin
                commit_d[ch*DATA_W +: DATA_W] = commit_din[ch*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q   <= 1'b0;
            started_q <= 1'b0;
            ended_q   <= 1'b0;
            ended2_q  <= 1'b0;
            reseted_q <= 1'b1;
            qual_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            cnt_q     <= '0;
            fidx_q    <= '0;
            commit_q  <= commit_init;
        end else begin
            start_q   <= start_d;
            started_q <= started_d;
            ended_q   <= ended_d;
            ended2_q  <= ended2_d;
            reseted_q <= reseted_d;
            qual_q    <= qual_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            cnt_q     <= cnt_d;
            fidx_q    <= fidx_d;
            commit_q  <= commit_d;
        end
    end

    assign start       = start_q;
    assign started     = started_q;
    assign ended       = ended_q;
    assign ended2      = ended2_q;
    assign reseted     = reseted_q;
    assign cycle_cnt   = cnt_q;
    assign iend        = iend_c;
    assign iend2       = iend2_c;
    assign mem_compare = iend_c | ended_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign vacuous     = started_q & ~qual_q;
    assign fail_idx    = fidx_q;

endmodule

// File: tb/tb_ila_refinement_monitor.sv
module tb_ila_refinement_monitor;

    logic        clk = 1'b0;
    logic        rst, issue, ila_valid, ila_decode;
    logic [15:0] map_eq, map_en;
    logic [17:0] commit_init, commit_din, commit_q;
    logic [1:0]  commit_we;
    logic        start, started, ended, ended2, reseted;
    logic [3:0]  cycle_cnt, fail_idx;
    logic        iend, iend2, mem_compare, pass, fail, vacuous;

    typedef struct packed {
        logic       start;
        logic       started;
        logic [3:0] cnt;
        logic       iend;
        logic       ended;
        logic       iend2;
        logic       ended2;
        logic       mem_cmp;
        logic       pass;
        logic       fail;
        logic       vac;
        logic [3:0] fidx;
    } rec_t;

    rec_t        exp_q[$];
    logic [17:0] cexp_q[$];
    int checks = 0;
    int errors = 0;

    ila_refinement_monitor dut (
        .clk(clk), .rst(rst), .issue(issue), .ila_valid(ila_valid), .ila_decode(ila_decode),
        .map_eq(map_eq), .map_en(map_en), .commit_init(commit_init), .commit_we(commit_we),
        .commit_din(commit_din), .commit_q(commit_q), .start(start), .started(started),
        .ended(ended), .ended2(ended2), .reseted(reseted), .cycle_cnt(cycle_cnt),
        .iend(iend), .iend2(iend2), .mem_compare(mem_compare), .pass(pass), .fail(fail),
        .vacuous(vacuous), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic rec_t dut_rec();
        return {start, started, cycle_cnt, iend, ended, iend2, ended2,
                mem_compare, pass, fail, vacuous, fail_idx};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        issue = 1'b0;
        commit_we = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rec_t act;
        commit_init = {9'h05A, 9'h1A5};
        ila_valid = 1'b0; ila_decode = 1'b0;
        map_eq = '1; map_en = '1; commit_din = '0;
        rst = 1'b1; issue = 1'b0; commit_we = '0;
        step();
        act = dut_rec();
        checks++;
        if (act !== rec_t'(0)) begin
            errors++;
            $display("FAIL reset_flags got=%h want=%h", act, rec_t'(0));
        end
        checks++;
        if (reseted !== 1'b1) begin
            errors++;
            $display("FAIL reset_reseted got=%b want=1", reseted);
        end
        checks++;
        if (commit_q !== 18'h0B5A5) begin
            errors++;
            $display("FAIL reset_commit got=%h want=%h", commit_q, 18'h0B5A5);
        end
        rst = 1'b0;
    endtask

    // Issue one instruction and follow it for 12 cycles against the expected timeline.
    task automatic run_issue(input string name, input logic v, input logic d,
                             input logic [15:0] eq, input logic [15:0] en, input bit reissue);
        logic        q;
        logic [15:0] bad;
        logic        f, p;
        logic [3:0]  idx;
        rec_t        r, act;
        q   = v & d;
        bad = ~eq & en;
        f   = q & (bad != 16'h0);
        p   = q & ~f;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (bad[i]) begin
                idx = 4'(i);
                break;
            end
        end
        ila_valid = v; ila_decode = d; map_eq = eq; map_en = en;
        for (int j = 0; j < 12; j++) begin
            r.start   = (j == 0);
            r.started = (j >= 1);
            r.cnt     = (j > 9) ? 4'd9 : 4'(j);
            r.iend    = (j == 4);
            r.ended   = (j >= 5);
            r.iend2   = (j == 6);
            r.ended2  = (j >= 7);
            r.mem_cmp = (j >= 4);
            r.pass    = p & (j >= 5);
            r.fail    = f & (j >= 5);
            r.vac     = (j >= 1) & ~q;
            r.fidx    = (f && j >= 5) ? idx : 4'd0;
            exp_q.push_back(r);
        end
        issue = 1'b1;
        for (int j = 0; j < 12; j++) begin
            step();
            issue = (reissue && j < 3) ? 1'b1 : 1'b0;
            r   = exp_q.pop_front();
            act = dut_rec();
            checks++;
            if (act !== r) begin
                errors++;
                $display("FAIL %s cycle %0d got=%h want=%h", name, j, act, r);
            end
        end
        issue = 1'b0;
    endtask

    task automatic test_commit_abort();
        rec_t act;
        do_reset();
        issue = 1'b1;
        step();
        issue = 1'b0;
        step();
        step();
        commit_we = 2'b01;
        commit_din = {9'h1FF, 9'h0F0};
        cexp_q.push_back({9'h05A, 9'h0F0});
        step();
        commit_we = '0;
        checks++;
        if (commit_q !== cexp_q.pop_front() || cycle_cnt !== 4'd3) begin
            errors++;
            $display("FAIL commit_write got=%h cnt=%0d want=%h cnt=3", commit_q, cycle_cnt, {9'h05A, 9'h0F0});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        act = dut_rec();
        checks++;
        if (act !== rec_t'(0) || commit_q !== 18'h0B5A5) begin
            errors++;
            $display("FAIL mid_abort got=%h commit=%h want=%h commit=%h", act, commit_q, rec_t'(0), 18'h0B5A5);
        end
    endtask

    task automatic test_commit_hold();
        do_reset();
        issue = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            issue = 1'b0;
        end
        commit_we = 2'b11;
        commit_din = {9'h111, 9'h022};
        cexp_q.push_back(18'h0B5A5);
        step();
        commit_we = '0;
        checks++;
        if (commit_q !== cexp_q.pop_front() || ended !== 1'b1) begin
            errors++;
            $display("FAIL commit_hold got=%h ended=%b want=%h ended=1", commit_q, ended, 18'h0B5A5);
        end
    endtask

    initial begin
        test_reset();
        run_issue("timeline_pass", 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        do_reset();
        run_issue("fail_idx", 1'b1, 1'b1, 16'hFF77, 16'hFFFF, 1'b0);
        do_reset();
        run_issue("vacuous", 1'b1, 1'b0, 16'h0000, 16'hFFFF, 1'b0);
        do_reset();
        run_issue("masked_reissue", 1'b1, 1'b1, 16'hFFF7, 16'hFFF7, 1'b1);
        test_commit_abort();
        run_issue("back_to_back", 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        test_commit_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
